// File: rtl/arf_rr_merge.sv
// rtl/arf_rr_merge.sv - round-robin merge of NUM_IN req/ack token sources onto one req/ack channel
module arf_rr_merge #(
    parameter int NUM_IN     = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [NUM_IN-1:0]            req_l,
    input  logic [NUM_IN-1:0]            ack_l,
    input  logic [NUM_IN*DATA_WIDTH-1:0] din,
    input  logic                         req_r,
    output logic                         ack_r,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic [ID_WIDTH-1:0]          dout_id,
    output logic [31:0]                  count
);
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_IN - 1);

    logic [NUM_IN-1:0]     full;
    logic [NUM_IN-1:0]     full_nxt;
    logic [NUM_IN-1:0]     capture;
    logic [DATA_WIDTH-1:0] data_q [NUM_IN];
    logic [ID_WIDTH-1:0]   ptr;
    logic                  gnt_vld;
    logic                  gnt_found;
    logic [ID_WIDTH-1:0]   gnt_id;
    logic [DATA_WIDTH-1:0] gnt_data;

    assign capture = ack_l & req_l;
    // ack_r gating enforces one idle cycle between forwarded tokens
    assign gnt_vld = req_r & ~ack_r & (|full);

    // First full slot at or above ptr, otherwise first full slot from 0 (wrap)
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!gnt_found && full[i] && (ID_WIDTH'(i) >= ptr)) begin
                gnt_found = 1'b1;
                gnt_id    = ID_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (!gnt_found && full[i]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_WIDTH'(i);
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        full_nxt = full | capture;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt_id == ID_WIDTH'(i)) begin
                gnt_data = data_q[i];
                if (gnt_vld) begin
                    full_nxt[i] = 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_IN; i++) begin : g_slot
        always_ff @(posedge clk) begin
            if (rst) begin
                req_l[i] <= 1'b0;
            end else if (capture[i]) begin
                req_l[i]  <= 1'b0;
                data_q[i] <= din[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (!full[i] && !req_l[i]) begin
                req_l[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full    <= '0;
            ptr     <= '0;
            ack_r   <= 1'b0;
            dout    <= '0;
            dout_id <= '0;
            count   <= '0;
        end else begin
            full  <= full_nxt;
            ack_r <= 1'b0;
            if (gnt_vld) begin
                ack_r   <= 1'b1;
                dout    <= gnt_data;
                dout_id <= gnt_id;
                ptr     <= (gnt_id == LAST_ID) ? '0 : gnt_id + ID_WIDTH'(1);
                count   <= count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_arf_rr_merge.sv
// tb/tb_arf_rr_merge.sv - directed and random self-checking bench for arf_rr_merge
module tb_arf_rr_merge;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_l, ack_l;
    logic [63:0] din;
    logic        req_r, ack_r;
    logic [31:0] dout;
    logic [0:0]  dout_id;
    logic [31:0] count;

    logic [2:0]  req_l3, ack_l3;
    logic [47:0] din3;
    logic        req_r3, ack_r3;
    logic [15:0] dout3;
    logic [1:0]  dout_id3;
    logic [31:0] count3;

    int errors = 0;
    int checks = 0;
    int n0, n1, e0, e1, got, total_sent, pr, cr;
    int sent [2];
    int exp_seq [2];
    logic exp_id, prev_ack;

    arf_rr_merge #(.NUM_IN(2), .DATA_WIDTH(32), .ID_WIDTH(1)) dut (
        .clk(clk), .rst(rst), .req_l(req_l), .ack_l(ack_l), .din(din),
        .req_r(req_r), .ack_r(ack_r), .dout(dout), .dout_id(dout_id), .count(count)
    );

    arf_rr_merge #(.NUM_IN(3), .DATA_WIDTH(16), .ID_WIDTH(2)) dut3 (
        .clk(clk), .rst(rst), .req_l(req_l3), .ack_l(ack_l3), .din(din3),
        .req_r(req_r3), .ack_r(ack_r3), .dout(dout3), .dout_id(dout_id3), .count(count3)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; ack_l = '0; din = '0; req_r = 1'b0;
        ack_l3 = '0; din3 = '0; req_r3 = 1'b0;

        // 1: reset
        step(); step(); step();
        chk("rst_req_l", req_l, 0);
        chk("rst_ack_r", ack_r, 0);
        chk("rst_count", count, 0);
        chk("rst_dout", dout, 0);
        rst = 1'b0;
        step();
        chk("rst_req_rise", req_l, 2'b11);

        // 2: single source
        ack_l = 2'b01; din = 64'h5; req_r = 1'b1;
        step();
        chk("single_req_after_cap", req_l, 2'b10);
        chk("single_no_early_ack", ack_r, 0);
        ack_l = '0;
        step();
        chk("single_ack_r", ack_r, 1);
        chk("single_dout", dout, 32'h5);
        chk("single_id", dout_id, 0);
        chk("single_count", count, 1);
        step();
        chk("single_rerise", req_l, 2'b11);
        chk("single_ack_drop", ack_r, 0);

        // 3: fairness
        req_r = 1'b0; rst = 1'b1; step(); rst = 1'b0; step();
        n0 = 0; n1 = 0; e0 = 0; e1 = 0; got = 0; exp_id = 1'b0; req_r = 1'b1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            ack_l = req_l;
            din = {32'h200 + 32'(n1), 32'h100 + 32'(n0)};
            step();
            if (ack_l[0]) n0++;
            if (ack_l[1]) n1++;
            if (ack_r) begin
                chk("fair_id", dout_id, exp_id);
                chk("fair_data", dout, exp_id ? 32'h200 + 32'(e1) : 32'h100 + 32'(e0));
                if (exp_id) e1++; else e0++;
                exp_id = ~exp_id;
                got++;
            end
        end
        ack_l = '0; req_r = 1'b0;
        chk("fair_got", got, 8);
        chk("fair_count", count, 8);

        // 4: backpressure
        rst = 1'b1; step(); rst = 1'b0; step();
        ack_l = 2'b11; din = {32'hB0, 32'hA0};
        step();
        ack_l = '0;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("bp_idle", {ack_r, req_l}, 3'b000);
        end
        req_r = 1'b1;
        step();
        chk("bp_first", {ack_r, dout_id, dout}, {1'b1, 1'b0, 32'hA0});
        step();
        chk("bp_gap", ack_r, 0);
        step();
        chk("bp_second", {ack_r, dout_id, dout}, {1'b1, 1'b1, 32'hB0});
        chk("bp_count", count, 2);
        req_r = 1'b0;

        // 6: reset mid-stream
        rst = 1'b1; step(); rst = 1'b0; step();
        ack_l = 2'b11; din = {32'hDEAD1, 32'hDEAD0};
        step();
        ack_l = '0; req_r = 1'b1;
        step();
        chk("mid_pre_ack", ack_r, 1);
        rst = 1'b1;
        step();
        chk("mid_rst_state", {ack_r, count, dout}, {1'b0, 32'h0, 32'h0});
        step();
        chk("mid_rst_hold", ack_r, 0);
        rst = 1'b0;
        step();
        chk("mid_req_rise", {ack_r, req_l}, 3'b011);
        ack_l = 2'b10; din = {32'h55, 32'h0};
        step();
        ack_l = '0;
        step();
        chk("mid_fresh", {ack_r, dout_id, dout}, {1'b1, 1'b1, 32'h55});
        chk("mid_count", count, 1);
        step();
        chk("mid_no_stale_a", ack_r, 0);
        step();
        chk("mid_no_stale_b", ack_r, 0);
        req_r = 1'b0;

        // 5: wrap with three sources
        ack_l3 = 3'b010; din3 = {16'h0, 16'h11, 16'h0};
        step();
        ack_l3 = '0; req_r3 = 1'b1;
        step();
        chk("wrap_g1", {ack_r3, dout_id3, dout3}, {1'b1, 2'd1, 16'h11});
        ack_l3 = 3'b101; din3 = {16'h32, 16'h0, 16'h30}; req_r3 = 1'b0;
        step();
        ack_l3 = '0; req_r3 = 1'b1;
        step();
        chk("wrap_g2", {ack_r3, dout_id3, dout3}, {1'b1, 2'd2, 16'h32});
        step();
        chk("wrap_gap", ack_r3, 0);
        step();
        chk("wrap_g0", {ack_r3, dout_id3, dout3}, {1'b1, 2'd0, 16'h30});
        chk("wrap_count", count3, 3);
        req_r3 = 1'b0;

        // random traffic
        rst = 1'b1; step(); rst = 1'b0;
        sent[0] = 0; sent[1] = 0; exp_seq[0] = 0; exp_seq[1] = 0;
        got = 0; total_sent = 0; pr = 0; cr = 0; prev_ack = 1'b0;
        for (int cyc = 0; cyc < 60000 && got < 5000; cyc++) begin
            if (cyc % 200 == 0) begin
                pr = int'($urandom_range(0, 50));
                cr = int'($urandom_range(0, 50));
            end
            for (int s = 0; s < 2; s++) begin
                ack_l[s] = req_l[s] && (total_sent < 5000) && (int'($urandom_range(0, 99)) >= pr);
                if (ack_l[s]) total_sent++;
            end
            din = {8'd1, 24'(sent[1]), 8'd0, 24'(sent[0])};
            req_r = int'($urandom_range(0, 99)) >= cr;
            prev_ack = ack_r;
            step();
            for (int s = 0; s < 2; s++) if (ack_l[s]) sent[s]++;
            if (ack_r) begin
                chk("rnd_b2b", prev_ack, 0);
                chk("rnd_data", dout, {7'd0, dout_id, 24'(exp_seq[dout_id])});
                exp_seq[dout_id]++;
                got++;
            end
        end
        ack_l = '0; req_r = 1'b1;
        repeat (6) step();
        chk("rnd_got", got, 5000);
        chk("rnd_count", count, 5000);
        chk("rnd_src0_all", exp_seq[0], sent[0]);
        chk("rnd_src1_all", exp_seq[1], sent[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
